// File: rtl/dma_burst_sequencer_pkg.sv
// Shared constants and state encoding for the DMA burst sequencer.
package dma_seq_pkg;

  localparam int          MEM_ENTRIES = 512;
  localparam int          BLOCK_W     = 10;
  localparam logic [31:0] WORD_BYTES  = 32'd4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_REQ   = 3'd1;
  localparam state_t ST_BEGIN = 3'd2;
  localparam state_t ST_RDATA = 3'd3;
  localparam state_t ST_WDATA = 3'd4;
  localparam state_t ST_WEND  = 3'd5;
  localparam state_t ST_NEXT  = 3'd6;
  localparam state_t ST_ERR   = 3'd7;

endpackage

// File: rtl/dma_burst_sequencer.sv
// Moves a block of words between the local SRAM and the system bus as a
// sequence of bursts no longer than the configured burst length.
//
// state | meaning
// IDLE  | waiting for start; all bus outputs low
// REQ   | requesting the bus, waiting for grant
// BEGIN | address/burst-size beat; SRAM read prefetch for writes
// RDATA | bus read data streamed into SRAM
// WDATA | SRAM data streamed onto the bus, stalls on slave busy
// WEND  | end-of-transaction beat after the last written word
// NEXT  | advance bus address; finish or request the next burst
// ERR   | slave error seen; bus released, done follows
module dma_burst_sequencer #(
  parameter int MEM_ENTRIES = dma_seq_pkg::MEM_ENTRIES,
  parameter int BLOCK_W     = dma_seq_pkg::BLOCK_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [31:0]                    cfg_bus_addr,
  input  logic [$clog2(MEM_ENTRIES)-1:0] cfg_mem_addr,
  input  logic [BLOCK_W-1:0]             cfg_block_size,
  input  logic [7:0]                     cfg_burst_size,
  input  logic                           cfg_dir,
  input  logic                           start,
  output logic [1:0]                     status,
  output logic                           done,
  output logic [$clog2(MEM_ENTRIES)-1:0] sram_addr,
  output logic [31:0]                    sram_wdata,
  output logic                           sram_we,
  input  logic [31:0]                    sram_rdata,
  output logic                           busOut_request,
  input  logic                           busIn_grants,
  output logic                           busOut_begin_transaction,
  output logic                           busOut_end_transaction,
  output logic                           busOut_data_valid,
  output logic [31:0]                    busOut_address_data,
  output logic [7:0]                     busOut_burst_size,
  output logic                           busOut_read_n_write,
  input  logic [31:0]                    busIn_address_data,
  input  logic                           busIn_data_valid,
  input  logic                           busIn_end_transaction,
  input  logic                           busIn_busy,
  input  logic                           busIn_error
);
  import dma_seq_pkg::*;

  localparam int AW = $clog2(MEM_ENTRIES);

  state_t             state;
  logic [31:0]        bus_addr;
  logic [AW-1:0]      mem_addr;
  logic [BLOCK_W-1:0] remaining;
  logic [7:0]         burst_cfg;
  logic               dir;
  logic [8:0]         burst_words;
  logic [8:0]         beat_left;
  logic               err;
  logic               done_r;

  logic [15:0] rem_ext, max_ext, burst_len;
  logic        wr_accept;

  function automatic logic [AW-1:0] mem_inc(input logic [AW-1:0] a);
    return (a == AW'(MEM_ENTRIES - 1)) ? '0 : a + 1'b1;
  endfunction

  assign rem_ext   = 16'(remaining);
  assign max_ext   = 16'(burst_cfg) + 16'd1;
  assign burst_len = (rem_ext < max_ext) ? rem_ext : max_ext;
  assign wr_accept = (state == ST_WDATA) && !busIn_busy && !busIn_error;

  assign status = {err, state != ST_IDLE};
  assign done   = done_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      bus_addr    <= '0;
      mem_addr    <= '0;
      remaining   <= '0;
      burst_cfg   <= '0;
      dir         <= 1'b0;
      burst_words <= '0;
      beat_left   <= '0;
      err         <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          bus_addr  <= cfg_bus_addr;
          mem_addr  <= cfg_mem_addr;
          remaining <= cfg_block_size;
          burst_cfg <= cfg_burst_size;
          dir       <= cfg_dir;
          err       <= 1'b0;
          if (cfg_block_size == '0) done_r <= 1'b1;
          else                      state  <= ST_REQ;
        end
        ST_REQ: if (busIn_grants) state <= ST_BEGIN;
        ST_BEGIN: begin
          if (busIn_error) begin
            state <= ST_ERR;
            err   <= 1'b1;
          end else begin
            burst_words <= 9'(burst_len);
            beat_left   <= 9'(burst_len);
            state       <= dir ? ST_WDATA : ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (busIn_error) begin
            state <= ST_ERR;
            err   <= 1'b1;
          end else begin
            if (busIn_data_valid) begin
              mem_addr <= mem_inc(mem_addr);
              if (remaining != '0) remaining <= remaining - 1'b1;
            end
            if (busIn_end_transaction) state <= ST_NEXT;
          end
        end
        ST_WDATA: begin
          if (busIn_error) begin
            state <= ST_ERR;
            err   <= 1'b1;
          end else if (wr_accept) begin
            mem_addr  <= mem_inc(mem_addr);
            beat_left <= beat_left - 1'b1;
            if (remaining != '0) remaining <= remaining - 1'b1;
            if (beat_left == 9'd1) state <= ST_WEND;
          end
        end
        ST_WEND: begin
          if (busIn_error) begin
            state <= ST_ERR;
            err   <= 1'b1;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          bus_addr <= bus_addr + (32'(burst_words) * WORD_BYTES);
          if (remaining == '0) begin
            state  <= ST_IDLE;
            done_r <= 1'b1;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_ERR: begin
          state  <= ST_IDLE;
          done_r <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busOut_request           = 1'b0;
    busOut_begin_transaction = 1'b0;
    busOut_end_transaction   = 1'b0;
    busOut_data_valid        = 1'b0;
    busOut_address_data      = '0;
    busOut_burst_size        = '0;
    busOut_read_n_write      = 1'b0;
    sram_addr                = '0;
    sram_wdata               = '0;
    sram_we                  = 1'b0;
    case (state)
      ST_REQ, ST_NEXT: begin
        busOut_request = 1'b1;
        sram_addr      = mem_addr;
      end
      ST_BEGIN: begin
        busOut_request           = 1'b1;
        busOut_begin_transaction = 1'b1;
        busOut_address_data      = bus_addr;
        busOut_burst_size        = 8'(burst_len - 16'd1);
        busOut_read_n_write      = ~dir;
        sram_addr                = mem_addr;
      end
      ST_RDATA: begin
        busOut_request = 1'b1;
        sram_addr      = mem_addr;
        sram_wdata     = busIn_address_data;
        sram_we        = busIn_data_valid && !busIn_error;
      end
      ST_WDATA: begin
        busOut_request      = 1'b1;
        busOut_data_valid   = 1'b1;
        busOut_address_data = sram_rdata;
        // Point at the next word once this one is taken so its read data
        // is ready on the following cycle; otherwise re-read the current word.
        sram_addr           = wr_accept ? mem_inc(mem_addr) : mem_addr;
      end
      ST_WEND: begin
        busOut_request         = 1'b1;
        busOut_end_transaction = 1'b1;
        sram_addr              = mem_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Bench for dma_burst_sequencer: table of transfers checked against a
// scoreboard of expected bus bursts, SRAM writes and bus write words.
module tb_dma_burst_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cfg_bus_addr;
  logic [8:0]  cfg_mem_addr;
  logic [9:0]  cfg_block_size;
  logic [7:0]  cfg_burst_size;
  logic        cfg_dir;
  logic        start;
  logic [1:0]  status;
  logic        done;
  logic [8:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_we;
  logic [31:0] sram_rdata;
  logic        busOut_request, busIn_grants;
  logic        busOut_begin_transaction, busOut_end_transaction, busOut_data_valid;
  logic [31:0] busOut_address_data;
  logic [7:0]  busOut_burst_size;
  logic        busOut_read_n_write;
  logic [31:0] busIn_address_data;
  logic        busIn_data_valid, busIn_end_transaction, busIn_busy, busIn_error;

  dma_burst_sequencer dut (
    .clock(clock), .reset(reset),
    .cfg_bus_addr(cfg_bus_addr), .cfg_mem_addr(cfg_mem_addr),
    .cfg_block_size(cfg_block_size), .cfg_burst_size(cfg_burst_size),
    .cfg_dir(cfg_dir), .start(start), .status(status), .done(done),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .sram_rdata(sram_rdata),
    .busOut_request(busOut_request), .busIn_grants(busIn_grants),
    .busOut_begin_transaction(busOut_begin_transaction),
    .busOut_end_transaction(busOut_end_transaction),
    .busOut_data_valid(busOut_data_valid),
    .busOut_address_data(busOut_address_data),
    .busOut_burst_size(busOut_burst_size),
    .busOut_read_n_write(busOut_read_n_write),
    .busIn_address_data(busIn_address_data),
    .busIn_data_valid(busIn_data_valid),
    .busIn_end_transaction(busIn_end_transaction),
    .busIn_busy(busIn_busy), .busIn_error(busIn_error)
  );

  always #5 clock = ~clock;
  assign busIn_grants = busOut_request;

  logic [31:0] sram [512];
  always @(posedge clock) begin
    if (sram_we) sram[sram_addr] <= sram_wdata;
    sram_rdata <= sram[sram_addr];
  end

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  bsize;
    logic        rnw;
  } beg_t;
  typedef struct {
    logic [8:0]  a;
    logic [31:0] d;
  } wr_t;
  typedef struct {
    logic [31:0] bus;
    logic [8:0]  mem;
    logic [9:0]  blk;
    logic [7:0]  burst;
    logic        dir;
    int          stall_word;
    int          stall_len;
    bit          poke;
    int          exp_bursts;
    logic [31:0] exp_last;
  } vec_t;

  beg_t        exp_begin[$];
  wr_t         exp_wr[$];
  logic [31:0] exp_bus[$];

  int          tests = 0, fails = 0;
  int          begin_cnt = 0, done_cnt = 0;
  logic [31:0] last_begin = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard side: pops expectations as the DUT produces them.
  always @(negedge clock) begin
    if (reset) begin
      if (busOut_begin_transaction) begin
        begin_cnt++;
        last_begin = busOut_address_data;
        if (exp_begin.size() == 0) chk("begin_unexpected", 1, 0);
        else begin
          beg_t e;
          e = exp_begin.pop_front();
          chk("begin_addr", busOut_address_data, e.addr);
          chk("begin_bsize", busOut_burst_size, e.bsize);
          chk("begin_rnw", busOut_read_n_write, e.rnw);
        end
      end
      if (sram_we) begin
        if (exp_wr.size() == 0) chk("sram_we_unexpected", 1, 0);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("sram_addr", sram_addr, w.a);
          chk("sram_wdata", sram_wdata, w.d);
        end
      end
      if (busOut_data_valid && !busIn_busy) begin
        if (exp_bus.size() == 0) chk("bus_word_unexpected", 1, 0);
        else chk("bus_wdata", busOut_address_data, exp_bus.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] b, input logic [8:0] m, input logic [9:0] n,
                         input logic [7:0] bs, input logic d);
    cfg_bus_addr = b; cfg_mem_addr = m; cfg_block_size = n;
    cfg_burst_size = bs; cfg_dir = d;
  endtask

  task automatic wait_begin(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (busOut_begin_transaction) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("begin_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   lens[$];
    int   rem, len, mem_e, wi, d0, b0;
    logic [31:0] ba, dat, held_d;
    logic [8:0]  held_a;
    bit   ok;
    rem = int'(v.blk);
    ba  = v.bus;
    while (rem > 0) begin
      len = (rem < int'(v.burst) + 1) ? rem : int'(v.burst) + 1;
      lens.push_back(len);
      exp_begin.push_back('{ba, 8'(len - 1), ~v.dir});
      ba  = ba + 32'(4 * len);
      rem = rem - len;
    end
    if (v.dir)
      for (int i = 0; i < int'(v.blk); i++) exp_bus.push_back(sram[(int'(v.mem) + i) % 512]);
    d0 = done_cnt;
    b0 = begin_cnt;
    set_cfg(v.bus, v.mem, v.blk, v.burst, v.dir);
    start = 1;
    tick();
    start = 0;
    if (v.poke) begin
      set_cfg(32'hDEAD_0000, 9'd7, 10'd1, 8'd0, ~v.dir);
      start = 1;
      tick();
      start = 0;
    end
    mem_e = int'(v.mem);
    wi = 0;
    foreach (lens[b]) begin
      wait_begin(ok);
      tick();
      if (!v.dir) begin
        for (int k = 0; k < lens[b]; k++) begin
          dat = $urandom;
          busIn_data_valid = 1;
          busIn_address_data = dat;
          busIn_end_transaction = (k == lens[b] - 1);
          exp_wr.push_back('{9'(mem_e), dat});
          mem_e = (mem_e + 1) % 512;
          tick();
        end
        busIn_data_valid = 0;
        busIn_end_transaction = 0;
      end else begin
        for (int k = 0; k < lens[b]; k++) begin
          if (wi == v.stall_word) begin
            busIn_busy = 1;
            #1;
            held_d = busOut_address_data;
            held_a = sram_addr;
            for (int s = 0; s < v.stall_len; s++) begin
              tick();
              chk("stall_hold_data", busOut_address_data, held_d);
              chk("stall_hold_addr", sram_addr, held_a);
            end
            busIn_busy = 0;
          end
          tick();
          wi++;
        end
        chk("wend_end", busOut_end_transaction, 1);
        chk("wend_dv", busOut_data_valid, 0);
        tick();
        chk("wend_one_cycle", busOut_end_transaction, 0);
      end
    end
    repeat (4) tick();
    chk($sformatf("v%0d_done", idx), done_cnt - d0, 1);
    chk($sformatf("v%0d_bursts", idx), begin_cnt - b0, v.exp_bursts);
    chk($sformatf("v%0d_last_addr", idx), last_begin, v.exp_last);
    chk($sformatf("v%0d_status", idx), status, 2'b00);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int mem_e, d0, b0;
    logic [31:0] dat;

    vecs[0] = '{32'h0000_1000, 9'd0,   10'd8,  8'd3,   1'b0, -1, 0, 1'b0, 2, 32'h0000_1010};
    vecs[1] = '{32'h0000_2000, 9'd20,  10'd10, 8'd3,   1'b0, -1, 0, 1'b0, 3, 32'h0000_2020};
    vecs[2] = '{32'h0000_3000, 9'd510, 10'd4,  8'd7,   1'b0, -1, 0, 1'b0, 1, 32'h0000_3000};
    vecs[3] = '{32'hFFFF_FFF8, 9'd100, 10'd6,  8'd1,   1'b1, -1, 0, 1'b0, 3, 32'h0000_0008};
    vecs[4] = '{32'h0000_4000, 9'd200, 10'd4,  8'd255, 1'b1,  1, 3, 1'b0, 1, 32'h0000_4000};
    vecs[5] = '{32'h0000_5000, 9'd300, 10'd3,  8'd7,   1'b0, -1, 0, 1'b1, 1, 32'h0000_5000};

    for (int i = 0; i < 512; i++) sram[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
    reset = 0; start = 0;
    set_cfg('0, '0, '0, '0, 0);
    busIn_address_data = '0; busIn_data_valid = 0; busIn_end_transaction = 0;
    busIn_busy = 0; busIn_error = 0;
    repeat (3) tick();
    chk("rst_status", status, 2'b00);
    chk("rst_done", done, 0);
    chk("rst_request", busOut_request, 0);
    chk("rst_sram_we", sram_we, 0);
    reset = 1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // error on the third read word
    exp_begin.push_back('{32'h0000_6000, 8'd7, 1'b1});
    d0 = done_cnt;
    set_cfg(32'h0000_6000, 9'd50, 10'd8, 8'd7, 1'b0);
    start = 1;
    tick();
    start = 0;
    wait_begin(ok);
    tick();
    mem_e = 50;
    for (int k = 0; k < 3; k++) begin
      dat = $urandom;
      busIn_data_valid = 1;
      busIn_address_data = dat;
      busIn_error = (k == 2);
      if (k < 2) exp_wr.push_back('{9'(mem_e), dat});
      mem_e++;
      tick();
    end
    busIn_data_valid = 0;
    busIn_error = 0;
    #1;
    chk("err_state_status", status, 2'b11);
    chk("err_state_request", busOut_request, 0);
    chk("err_state_dv", busOut_data_valid, 0);
    tick();
    chk("err_done", done, 1);
    chk("err_idle_status", status, 2'b10);
    tick();
    chk("err_done_one_cycle", done, 0);
    chk("err_sticky", status, 2'b10);
    chk("err_done_count", done_cnt - d0, 1);

    // zero-length block: done next cycle, no request, clears sticky error
    b0 = begin_cnt;
    set_cfg(32'h0000_8000, 9'd0, 10'd0, 8'd3, 1'b0);
    start = 1;
    tick();
    start = 0;
    chk("blk0_done", done, 1);
    chk("blk0_request", busOut_request, 0);
    chk("blk0_status_cleared", status, 2'b00);
    tick();
    chk("blk0_done_one_cycle", done, 0);
    chk("blk0_no_burst", begin_cnt - b0, 0);

    // reset in the middle of a read burst
    exp_begin.push_back('{32'h0000_7000, 8'd7, 1'b1});
    set_cfg(32'h0000_7000, 9'd400, 10'd8, 8'd7, 1'b0);
    start = 1;
    tick();
    start = 0;
    wait_begin(ok);
    tick();
    mem_e = 400;
    for (int k = 0; k < 2; k++) begin
      dat = $urandom;
      busIn_data_valid = 1;
      busIn_address_data = dat;
      exp_wr.push_back('{9'(mem_e), dat});
      mem_e++;
      tick();
    end
    busIn_data_valid = 0;
    reset = 0;
    #1;
    chk("midrst_request", busOut_request, 0);
    chk("midrst_end", busOut_end_transaction, 0);
    chk("midrst_dv", busOut_data_valid, 0);
    chk("midrst_begin", busOut_begin_transaction, 0);
    chk("midrst_sram_we", sram_we, 0);
    chk("midrst_status", status, 2'b00);
    chk("midrst_done", done, 0);
    exp_begin.delete();
    repeat (2) tick();
    reset = 1;
    repeat (2) tick();
    chk("postrst_request", busOut_request, 0);
    chk("postrst_status", status, 2'b00);

    chk("left_begins", exp_begin.size(), 0);
    chk("left_sram_writes", exp_wr.size(), 0);
    chk("left_bus_words", exp_bus.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dma_burst_sequencer.md
DMA_BURST_SEQUENCER -- requirements
Module: dma_burst_sequencer

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter: MEM_ENTRIES, 512, SRAM depth in 32-bit words; memory address width is log2(MEM_ENTRIES) = 9.
REQ-003 Parameter: BLOCK_W, 10, width of the block-size field in words.
REQ-004 Ports SHALL be:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- cfg_bus_addr  input  32  byte start address on bus
- cfg_mem_addr  input  9  SRAM start word address
- cfg_block_size  input  10  total words to move
- cfg_burst_size  input  8  max burst length minus 1
- cfg_dir  input  1  0 = bus-to-SRAM, 1 = SRAM-to-bus
- start  input  1  one-cycle launch pulse
- status  output  2  bit0 busy, bit1 error
- done  output  1  one-cycle completion pulse
- sram_addr  output  9  SRAM port address
- sram_wdata  output  32  SRAM write data
- sram_we  output  1  SRAM write enable
- sram_rdata  input  32  SRAM read data, 1-cycle latency
- busOut_request  output  1  bus request
- busIn_grants  input  1  bus grant
- busOut_begin_transaction, busOut_end_transaction, busOut_data_valid  output  1 each  bus framing
- busOut_address_data  output  32  address in begin cycle, data otherwise
- busOut_burst_size  output  8  words minus 1
- busOut_read_n_write  output  1  1 = read
- busIn_address_data  input  32  read data
- busIn_data_valid, busIn_end_transaction, busIn_busy, busIn_error  input  1 each  slave handshake

Function
REQ-005 SHALL latch all cfg_* on an accepted start (start=1 in IDLE); start outside IDLE SHALL be ignored.
REQ-006 start with cfg_block_size=0 SHALL produce done=1 next cycle with no bus activity.
REQ-007 States SHALL be IDLE, REQ, BEGIN, RDATA, WDATA, WEND, NEXT, ERR.
REQ-008 REQ: busOut_request=1 until busIn_grants=1 sampled, then go to BEGIN; request SHALL stay high through NEXT.
REQ-009 BEGIN (exactly 1 cycle): begin_transaction=1, address_data=current bus addr, burst_size=min(remaining, cfg_burst_size+1)-1, read_n_write=~cfg_dir; go to RDATA if cfg_dir=0, else WDATA.
REQ-010 RDATA: each cycle with busIn_data_valid=1, sram_we=1, sram_wdata=busIn_address_data, sram_addr=mem addr; mem addr +1 mod 512; remaining -1.
REQ-011 RDATA: busIn_end_transaction=1 SHALL go to NEXT; a data_valid in the same cycle SHALL still be written.
REQ-012 WDATA: sram_addr SHALL be prefetched in BEGIN; data_valid=1 with address_data=sram_rdata; a word is accepted when busIn_busy=0; on busy=1, data and address SHALL hold.
REQ-013 WDATA: after the last accepted word of the burst, go to WEND; WEND drives end_transaction=1, data_valid=0 for 1 cycle, then goes to NEXT.
REQ-014 NEXT: bus addr += 4*(burst words); if remaining=0, go to IDLE with request=0 and done=1 for 1 cycle; otherwise go to REQ.
REQ-015 busIn_error=1 in BEGIN/RDATA/WDATA/WEND SHALL go to ERR: all bus outputs 0, status[1]=1; next cycle go to IDLE with done=1.
REQ-016 status[1] SHALL stay sticky until the next accepted start; status[0]=1 in every state except IDLE.
REQ-017 SRAM address wrap-around past 511 to 0 SHALL be silent; bus address SHALL wrap modulo 2^32.
REQ-018 In the idle state, all bus outputs and sram_we SHALL be 0.

Reset
REQ-019 Asserting reset SHALL force IDLE at any time, including mid-burst, with all outputs 0, status=0 and counters 0; no end_transaction is issued.

Structure
REQ-020 Package dma_seq_pkg SHALL hold the state enum, MEM_ENTRIES, BLOCK_W and the bus-word byte stride (4).
REQ-021 The FSM, counters and burst-length computation SHALL live in one module; no sub-module is needed.

Verification
REQ-022 Read: bus 0x1000, mem 0, block 8, burst 3, dir 0, immediate grant -> two bursts of burst_size 3 at 0x1000 and 0x1010; SRAM[0..7] written; one done pulse.
REQ-023 Uneven: block 10, burst 3 -> third burst has burst_size 1 at address+0x20; 10 words total.
REQ-024 Write with stalls: dir 1, block 4, busIn_busy high on the 2nd word for 3 cycles -> data held; WEND 1 cycle; 4 distinct words in order.
REQ-025 Wrap: mem 510, block 4 -> SRAM writes to 510, 511, 0, 1.
REQ-026 Error: busIn_error on the 3rd read word -> ERR; status=2'b10 after; done pulse; a new start clears status[1].
REQ-027 Reset mid-RDATA, plus start during busy and block 0 -> outputs 0 immediately; ignored start produces no effect; block 0 gives done the next cycle with no request.
